iomem_debug_master: RTL and testbench

//  Byte-stream-to-iomem bus initiator. Host debug tool drives the iomem peripheral bus (e.g. GPIO at 0x03xx_xxxx).

---
 rtl/iomem_dbg_pkg.sv | 28 ++
 rtl/iomem_dbg_resp_shift.sv | 51 +++++
 rtl/iomem_debug_master.sv | 197 +++++++++++++++++++
 tb/tb_iomem_debug_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iomem_dbg_pkg
// Description : Frame opcodes, response codes and FSM states for the
//               byte-stream iomem debug master.
// Revision    : 1.0 - initial release
// ============================================================================
package iomem_dbg_pkg;

    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] OP_RD    = 8'h52;

    localparam logic [7:0] RSP_ACK  = 8'h6B;
    localparam logic [7:0] RSP_DATA = 8'h64;
    localparam logic [7:0] RSP_ERR  = 8'h3F;
    localparam logic [7:0] RSP_TMO  = 8'h74;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_STRB  = 3'd2,
        ST_WDATA = 3'd3,
        ST_BUS   = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iomem_dbg_resp_shift.sv
`default_nettype none
// ============================================================================
// Module      : iomem_dbg_resp_shift
// Description : Response serializer; emits a header byte and an optional
//               32-bit word MSB first under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_dbg_resp_shift (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  hdr,
    input  logic [31:0] word,
    input  logic        with_word,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [39:0] r_shift;
    logic [2:0]  r_left;
    logic        r_active;

    assign tx_data  = r_shift[39:32];
    assign tx_valid = r_active;
    assign done     = r_active && tx_ready && (r_left == 3'd0);

    // Shift register is cleared after the last byte so tx_data idles at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= 40'h0;
            r_left   <= 3'd0;
            r_active <= 1'b0;
        end else if (load) begin
            r_shift  <= with_word ? {hdr, word} : {hdr, 32'h0};
            r_left   <= with_word ? 3'd4 : 3'd0;
            r_active <= 1'b1;
        end else if (r_active && tx_ready) begin
            if (r_left == 3'd0) begin
                r_shift  <= 40'h0;
                r_active <= 1'b0;
            end else begin
                r_shift <= {r_shift[31:0], 8'h00};
                r_left  <= r_left - 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iomem_debug_master.sv
`default_nettype none
// ============================================================================
// Module      : iomem_debug_master
// Description : Parses W/R command frames from a byte stream, issues one
//               iomem transaction per frame and returns a response frame.
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_debug_master
    import iomem_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic        r_is_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [15:0] r_tmo_cnt;

    logic        w_rx_fire;
    logic        w_last_byte;
    logic        w_tmo_hit;
    logic        w_resp_load;
    logic        w_resp_with_word;
    logic [7:0]  w_resp_hdr;
    logic        w_resp_done;

    assign w_rx_fire   = rx_valid && rx_ready;
    assign w_last_byte = (r_idx == 2'd3);
    assign w_tmo_hit   = (r_tmo_cnt == c_tmo_last);

    assign iomem_addr  = r_addr;
    assign iomem_wdata = r_wdata;
    assign iomem_wstrb = r_wstrb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (w_rx_fire && w_last_byte) begin
                    w_state_nxt = r_is_wr ? ST_STRB : ST_BUS;
                end
            end
            ST_STRB: begin
                if (w_rx_fire) begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (w_rx_fire && w_last_byte) begin
                    w_state_nxt = (r_wstrb == 4'h0) ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (iomem_ready || w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_resp_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The response is loaded on the same edge that enters RESP, so tx_valid
    // is already high in the first RESP cycle.
    always_comb begin
        rx_ready         = (r_state == ST_IDLE) || (r_state == ST_ADDR) ||
                           (r_state == ST_STRB) || (r_state == ST_WDATA);
        busy             = (r_state != ST_IDLE);
        iomem_valid      = (r_state == ST_BUS);
        w_resp_load      = 1'b0;
        w_resp_hdr       = RSP_ERR;
        w_resp_with_word = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire && rx_data != OP_WR && rx_data != OP_RD) begin
                    w_resp_load = 1'b1;
                    w_resp_hdr  = RSP_ERR;
                end
            end
            ST_WDATA: begin
                if (w_rx_fire && w_last_byte && r_wstrb == 4'h0) begin
                    w_resp_load = 1'b1;
                    w_resp_hdr  = RSP_ACK;
                end
            end
            ST_BUS: begin
                if (iomem_ready) begin
                    w_resp_load      = 1'b1;
                    w_resp_hdr       = r_is_wr ? RSP_ACK : RSP_DATA;
                    w_resp_with_word = !r_is_wr;
                end else if (w_tmo_hit) begin
                    w_resp_load = 1'b1;
                    w_resp_hdr  = RSP_TMO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= 2'd0;
            r_is_wr   <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_tmo_cnt <= 16'h0;
        end else begin
            if (w_rx_fire) begin
                case (r_state)
                    ST_IDLE: begin
                        r_idx   <= 2'd0;
                        r_is_wr <= (rx_data == OP_WR);
                        r_wdata <= 32'h0;
                        r_wstrb <= 4'h0;
                    end
                    ST_ADDR: begin
                        r_addr <= {r_addr[23:0], rx_data};
                        r_idx  <= r_idx + 2'd1;
                    end
                    ST_STRB: begin
                        r_wstrb <= rx_data[3:0];
                    end
                    ST_WDATA: begin
                        r_wdata <= {r_wdata[23:0], rx_data};
                        r_idx   <= r_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            // Counter sits at zero outside BUS, so it starts clean on entry.
            if (r_state == ST_BUS && !iomem_ready) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= 16'h0;
            end
        end
    end

    iomem_dbg_resp_shift u_resp_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (w_resp_load),
        .hdr       (w_resp_hdr),
        .word      (iomem_rdata),
        .with_word (w_resp_with_word),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (w_resp_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_iomem_debug_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_iomem_debug_master
// Description : Scoreboard bench for iomem_debug_master with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_debug_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          len;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [7:0]  tx_q[$];
    int          checks = 0;
    int          errors = 0;
    int          resp_en = 1;
    int          resp_delay = 1;
    logic [31:0] resp_rdata = 32'h0;
    int          tx_mode = 0;
    int          wcnt = 0;
    logic        stall = 1'b0;
    logic [7:0]  held = 8'h0;
    logic        bus_prev = 1'b0;
    bus_exp_t    cur;
    int          vlen = 0;

    iomem_debug_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // iomem responder: ready pulses resp_delay cycles after valid rises
    initial begin
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (iomem_ready) begin
                iomem_ready = 1'b0;
                iomem_rdata = 32'h0;
                wcnt = 0;
            end else if (iomem_valid && resp_en != 0) begin
                if (wcnt >= resp_delay) begin
                    iomem_ready = 1'b1;
                    iomem_rdata = resp_rdata;
                end else begin
                    wcnt++;
                end
            end else if (!iomem_valid) begin
                wcnt = 0;
            end
        end
    end

    // tx sink: 0 = always ready, 1 = toggling, 2 = stalled
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // tx monitor / scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("tx_hold_valid", 32'(tx_valid), 32'd1);
                    check("tx_hold_data", 32'(tx_data), 32'(held));
                end
                if (tx_valid && tx_ready) begin
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                    end else begin
                        e = tx_q.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(e));
                    end
                end
                if (tx_valid || iomem_valid) begin
                    check("rx_ready_low", 32'(rx_ready), 32'd0);
                end
                stall = tx_valid && !tx_ready;
                held  = tx_data;
            end
        end
    end

    // bus monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (iomem_valid && !bus_prev) begin
                vlen = 1;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got addr %h expected no request", iomem_addr);
                    cur.addr  = iomem_addr;
                    cur.wstrb = iomem_wstrb;
                    cur.wdata = iomem_wdata;
                    cur.len   = 0;
                end else begin
                    cur = bus_q.pop_front();
                    check("bus_addr", iomem_addr, cur.addr);
                    check("bus_wstrb", 32'(iomem_wstrb), 32'(cur.wstrb));
                    check("bus_wdata", iomem_wdata, cur.wdata);
                end
            end else if (iomem_valid) begin
                vlen++;
                check("bus_addr_stable", iomem_addr, cur.addr);
            end else if (bus_prev && cur.len != 0) begin
                check("bus_valid_len", 32'(vlen), 32'(cur.len));
            end
            bus_prev = iomem_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) fail_now("rx_accept");
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [7:0] s, input logic [31:0] d);
        logic [31:0] av;
        logic [31:0] dv;
        av = a;
        dv = d;
        send_byte(8'h57);
        for (int i = 3; i >= 0; i--) send_byte(av[i*8 +: 8]);
        send_byte(s);
        for (int i = 3; i >= 0; i--) send_byte(dv[i*8 +: 8]);
    endtask

    task automatic send_read(input logic [31:0] a);
        logic [31:0] av;
        av = a;
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(av[i*8 +: 8]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((tx_q.size() != 0 || bus_q.size() != 0 || busy) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic push_read_resp(input logic [31:0] d);
        tx_q.push_back(8'h64);
        tx_q.push_back(d[31:24]);
        tx_q.push_back(d[23:16]);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[7:0]);
    endtask

    task automatic pulse_reset_and_check(input string name);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check({name, "_valid"},  32'(iomem_valid), 32'd0);
        check({name, "_txvalid"}, 32'(tx_valid), 32'd0);
        check({name, "_txdata"},  32'(tx_data), 32'd0);
        check({name, "_busy"},    32'(busy), 32'd0);
        check({name, "_rxready"}, 32'(rx_ready), 32'd1);
        check({name, "_addr"},    iomem_addr, 32'd0);
        tx_q.delete();
        bus_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_iomem_valid", 32'(iomem_valid), 32'd0);
        check("rst_wstrb", 32'(iomem_wstrb), 32'd0);
        check("rst_addr", iomem_addr, 32'd0);
        check("rst_wdata", iomem_wdata, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: full-strobe write
        bus_q.push_back('{32'h03000000, 4'hF, 32'h000000A5, 0});
        tx_q.push_back(8'h6B);
        send_write(32'h03000000, 8'h0F, 32'h000000A5);
        @(negedge clk);
        check("wr_valid_latency", 32'(iomem_valid), 32'd1);
        wait_done("wr_done");

        // 2: read, zero-wait sink gives 5 consecutive tx cycles
        resp_rdata = 32'h000000A5;
        bus_q.push_back('{32'h03000000, 4'h0, 32'h0, 0});
        push_read_resp(32'h000000A5);
        send_read(32'h03000000);
        n = 0;
        while (!tx_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (tx_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("rd_tx_cycles", 32'(n), 32'd5);
        wait_done("rd_done");

        // 3: no responder -> 16-cycle valid then 't'
        resp_en = 0;
        bus_q.push_back('{32'h04000000, 4'h0, 32'h0, 16});
        tx_q.push_back(8'h74);
        send_read(32'h04000000);
        wait_done("tmo_done");
        resp_en = 1;

        // 4: bad opcode then normal read
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        wait_done("bad_op_done");
        bus_q.push_back('{32'h03000000, 4'h0, 32'h0, 0});
        push_read_resp(32'h000000A5);
        send_read(32'h03000000);
        wait_done("rd2_done");

        // 5: read with toggling sink
        tx_mode = 1;
        resp_rdata = 32'h12345678;
        bus_q.push_back('{32'h03000008, 4'h0, 32'h0, 0});
        push_read_resp(32'h12345678);
        send_read(32'h03000008);
        wait_done("rd_toggle_done");
        tx_mode = 0;

        // zero strobe skips the bus; upper strobe nibble ignored
        tx_q.push_back(8'h6B);
        send_write(32'h03000010, 8'hF0, 32'hDEADBEEF);
        wait_done("wr_zero_strb_done");
        bus_q.push_back('{32'h03000004, 4'h3, 32'h11223344, 0});
        tx_q.push_back(8'h6B);
        send_write(32'h03000004, 8'hA3, 32'h11223344);
        wait_done("wr_partial_done");

        // 6: reset mid-BUS
        resp_en = 0;
        bus_q.push_back('{32'h04000000, 4'h0, 32'h0, 0});
        send_read(32'h04000000);
        repeat (3) @(posedge clk);
        pulse_reset_and_check("rst_bus");
        resp_en = 1;

        // reset mid-RESP
        tx_mode = 2;
        resp_rdata = 32'h000000A5;
        bus_q.push_back('{32'h03000000, 4'h0, 32'h0, 0});
        send_read(32'h03000000);
        n = 0;
        while (!tx_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!tx_valid) fail_now("resp_wait");
        repeat (2) @(negedge clk);
        pulse_reset_and_check("rst_resp");
        tx_mode = 0;

        bus_q.push_back('{32'h03000000, 4'hF, 32'h000000A5, 0});
        tx_q.push_back(8'h6B);
        send_write(32'h03000000, 8'h0F, 32'h000000A5);
        wait_done("wr_after_rst_done");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
